// File: rtl/hpdcache_core_req_arb.sv
// Round-robin arbiter sharing one HPDcache core requester port among N_CLIENTS clients.
// Sequences the two-phase request protocol: the request is issued in cycle 0, and
// tag/PMA/abort follow in cycle 1 from the same client. Responses are routed back
// using the client index carried in the upper bits of the downstream TID.
// Per-client outstanding-response counters allow draining or throttling a client.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   cl_req_*             per-client request (valid/ready, payload, tid, need_rsp)
//                        and phase-2 fields (tag, pma, abort)
//   cl_rsp_*             per-client response valid; payload and tid broadcast
//   cl_outst_o           per-client outstanding response count
//   idle_o               no phase 2 pending and all counters zero
//   dc_req_*, dc_rsp_*   downstream cache requester port
module hpdcache_core_req_arb #(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned REQ_W     = 128,
  parameter int unsigned TID_W     = 4,
  parameter int unsigned TAG_W     = 44,
  parameter int unsigned PMA_W     = 2,
  parameter int unsigned RSP_W     = 72,
  parameter int unsigned MAX_OUTST = 4,
  localparam int unsigned IDX_W    = $clog2(N_CLIENTS),
  localparam int unsigned CNT_W    = $clog2(MAX_OUTST + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_CLIENTS-1:0]                cl_req_valid_i,
  output logic [N_CLIENTS-1:0]                cl_req_ready_o,
  input  logic [N_CLIENTS-1:0][REQ_W-1:0]     cl_req_i,
  input  logic [N_CLIENTS-1:0][TID_W-1:0]     cl_req_tid_i,
  input  logic [N_CLIENTS-1:0]                cl_req_need_rsp_i,
  input  logic [N_CLIENTS-1:0][TAG_W-1:0]     cl_req_tag_i,
  input  logic [N_CLIENTS-1:0][PMA_W-1:0]     cl_req_pma_i,
  input  logic [N_CLIENTS-1:0]                cl_req_abort_i,
  output logic [N_CLIENTS-1:0]                cl_rsp_valid_o,
  output logic [N_CLIENTS-1:0][RSP_W-1:0]     cl_rsp_o,
  output logic [N_CLIENTS-1:0][TID_W-1:0]     cl_rsp_tid_o,
  output logic [N_CLIENTS-1:0][CNT_W-1:0]     cl_outst_o,
  output logic                                idle_o,
  output logic                                dc_req_valid_o,
  input  logic                                dc_req_ready_i,
  output logic [REQ_W-1:0]                    dc_req_o,
  output logic [TID_W+IDX_W-1:0]              dc_req_tid_o,
  output logic [TAG_W-1:0]                    dc_req_tag_o,
  output logic [PMA_W-1:0]                    dc_req_pma_o,
  output logic                                dc_req_abort_o,
  input  logic                                dc_rsp_valid_i,
  input  logic [RSP_W-1:0]                    dc_rsp_i,
  input  logic [TID_W+IDX_W-1:0]              dc_rsp_tid_i
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTST);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_CLIENTS - 1);

  logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                             lock_q, lock_d;
  logic [IDX_W-1:0]                 lock_idx_q, lock_idx_d;
  logic                             p2_valid_q, p2_valid_d;
  logic [IDX_W-1:0]                 p2_idx_q, p2_idx_d;
  logic                             p2_need_q, p2_need_d;
  logic [N_CLIENTS-1:0][CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_CLIENTS-1:0] eligible;
  logic [N_CLIENTS-1:0] inc, dec;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic                 accept;
  logic [IDX_W-1:0]     rsp_idx;
  int unsigned          cand;
  logic [IDX_W-1:0]     cand_idx;

  assign rsp_idx = dc_rsp_tid_i[TID_W +: IDX_W];

  // A client that needs no response is never throttled by its counter.
  always_comb begin
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      eligible[i] = cl_req_valid_i[i] & (~cl_req_need_rsp_i[i] | (cnt_q[i] < MaxCnt));
    end
  end

  // Lock holds the grant on a stalled client so the payload cannot switch under it.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    if (lock_q) begin
      grant_valid = cl_req_valid_i[lock_idx_q];
      grant_idx   = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < N_CLIENTS; k++) begin
        cand     = (32'(rr_ptr_q) + k) % N_CLIENTS;
        cand_idx = IDX_W'(cand);
        if (!grant_valid && eligible[cand_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  assign accept         = grant_valid & dc_req_ready_i;
  assign dc_req_valid_o = grant_valid;
  assign dc_req_o       = cl_req_i[grant_idx];
  assign dc_req_tid_o   = {grant_idx, cl_req_tid_i[grant_idx]};

  always_comb begin
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      cl_req_ready_o[i] = accept & (grant_idx == IDX_W'(i));
      cl_rsp_valid_o[i] = dc_rsp_valid_i & (rsp_idx == IDX_W'(i));
      cl_rsp_o[i]       = dc_rsp_i;
      cl_rsp_tid_o[i]   = dc_rsp_tid_i[TID_W-1:0];
    end
  end

  // Phase 2 outputs follow the client accepted in the previous cycle.
  always_comb begin
    dc_req_tag_o   = '0;
    dc_req_pma_o   = '0;
    dc_req_abort_o = 1'b0;
    if (p2_valid_q) begin
      dc_req_tag_o   = cl_req_tag_i[p2_idx_q];
      dc_req_pma_o   = cl_req_pma_i[p2_idx_q];
      dc_req_abort_o = cl_req_abort_i[p2_idx_q];
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    if (accept) rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    lock_d     = grant_valid & ~dc_req_ready_i;
    lock_idx_d = lock_d ? grant_idx : lock_idx_q;
    p2_valid_d = accept;
    p2_idx_d   = accept ? grant_idx : p2_idx_q;
    p2_need_d  = accept & cl_req_need_rsp_i[grant_idx];
  end

  // An aborted request that expected a response will never get one: release its slot.
  always_comb begin
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      inc[i]   = cl_req_ready_o[i] & cl_req_need_rsp_i[i];
      dec[i]   = cl_rsp_valid_o[i] |
                 (p2_valid_q & p2_need_q & (p2_idx_q == IDX_W'(i)) & cl_req_abort_i[i]);
      cnt_d[i] = cnt_q[i];
      unique case ({inc[i], dec[i]})
        2'b10:   if (cnt_q[i] < MaxCnt) cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  assign cl_outst_o = cnt_q;
  assign idle_o     = ~p2_valid_q & (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      p2_valid_q <= 1'b0;
      p2_idx_q   <= '0;
      p2_need_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      p2_valid_q <= p2_valid_d;
      p2_idx_q   <= p2_idx_d;
      p2_need_q  <= p2_need_d;
      cnt_q      <= cnt_d;
    end
  end

  // A decrement at zero means a response nobody was waiting for.
  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_chk
    dec_at_zero: assert property (@(posedge clk_i) disable iff (rst_i)
      !(dec[g] && cnt_q[g] == '0));
  end

endmodule

// File: tb/tb_hpdcache_core_req_arb.sv
module tb_hpdcache_core_req_arb;

  localparam int unsigned N     = 4;
  localparam int unsigned REQ_W = 128;
  localparam int unsigned TID_W = 4;
  localparam int unsigned TAG_W = 44;
  localparam int unsigned PMA_W = 2;
  localparam int unsigned RSP_W = 72;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N-1:0]                cl_req_valid;
  logic [N-1:0]                cl_req_ready;
  logic [N-1:0][REQ_W-1:0]     cl_req;
  logic [N-1:0][TID_W-1:0]     cl_req_tid;
  logic [N-1:0]                cl_req_need_rsp;
  logic [N-1:0][TAG_W-1:0]     cl_req_tag;
  logic [N-1:0][PMA_W-1:0]     cl_req_pma;
  logic [N-1:0]                cl_req_abort;
  logic [N-1:0]                cl_rsp_valid;
  logic [N-1:0][RSP_W-1:0]     cl_rsp;
  logic [N-1:0][TID_W-1:0]     cl_rsp_tid;
  logic [N-1:0][CNT_W-1:0]     cl_outst;
  logic                        idle;
  logic                        dc_req_valid;
  logic                        dc_req_ready;
  logic [REQ_W-1:0]            dc_req;
  logic [TID_W+IDX_W-1:0]      dc_req_tid;
  logic [TAG_W-1:0]            dc_req_tag;
  logic [PMA_W-1:0]            dc_req_pma;
  logic                        dc_req_abort;
  logic                        dc_rsp_valid;
  logic [RSP_W-1:0]            dc_rsp;
  logic [TID_W+IDX_W-1:0]      dc_rsp_tid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hpdcache_core_req_arb dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .cl_req_valid_i    (cl_req_valid),
    .cl_req_ready_o    (cl_req_ready),
    .cl_req_i          (cl_req),
    .cl_req_tid_i      (cl_req_tid),
    .cl_req_need_rsp_i (cl_req_need_rsp),
    .cl_req_tag_i      (cl_req_tag),
    .cl_req_pma_i      (cl_req_pma),
    .cl_req_abort_i    (cl_req_abort),
    .cl_rsp_valid_o    (cl_rsp_valid),
    .cl_rsp_o          (cl_rsp),
    .cl_rsp_tid_o      (cl_rsp_tid),
    .cl_outst_o        (cl_outst),
    .idle_o            (idle),
    .dc_req_valid_o    (dc_req_valid),
    .dc_req_ready_i    (dc_req_ready),
    .dc_req_o          (dc_req),
    .dc_req_tid_o      (dc_req_tid),
    .dc_req_tag_o      (dc_req_tag),
    .dc_req_pma_o      (dc_req_pma),
    .dc_req_abort_o    (dc_req_abort),
    .dc_rsp_valid_i    (dc_rsp_valid),
    .dc_rsp_i          (dc_rsp),
    .dc_rsp_tid_i      (dc_rsp_tid)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] valid;
    logic [3:0] need;
    logic [3:0] abort;
    logic       ready;
    logic       rsp_v;
    logic [5:0] rsp_tid;
    logic       e_dv;
    logic [5:0] e_tid;
    logic [3:0] e_rdy;
    logic       e_p2v;
    logic [1:0] e_p2i;
    logic       e_abort;
    logic [11:0] e_outst;
    logic       e_idle;
    logic [3:0] e_rspv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic r, input logic [3:0] va,
                              input logic [3:0] ne, input logic [3:0] ab, input logic rd,
                              input logic rv, input logic [5:0] rt, input logic edv,
                              input logic [5:0] etid, input logic [3:0] erdy, input logic ep2v,
                              input logic [1:0] ep2i, input logic eab, input logic [11:0] eo,
                              input logic eidle, input logic [3:0] erspv);
    vec_t v;
    v.name = nm; v.rst = r; v.valid = va; v.need = ne; v.abort = ab; v.ready = rd;
    v.rsp_v = rv; v.rsp_tid = rt; v.e_dv = edv; v.e_tid = etid; v.e_rdy = erdy;
    v.e_p2v = ep2v; v.e_p2i = ep2i; v.e_abort = eab; v.e_outst = eo; v.e_idle = eidle;
    v.e_rspv = erspv;
    return v;
  endfunction

  function automatic logic [11:0] oc(input int c3, input int c2, input int c1, input int c0);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic apply(input vec_t v);
    logic [TAG_W-1:0] e_tag;
    logic [PMA_W-1:0] e_pma;
    logic [RSP_W-1:0] e_rsp;
    logic [11:0]      act_o;
    logic             ok;
    @(negedge clk);
    rst             = v.rst;
    cl_req_valid    = v.valid;
    cl_req_need_rsp = v.need;
    cl_req_abort    = v.abort;
    dc_req_ready    = v.ready;
    dc_rsp_valid    = v.rsp_v;
    dc_rsp_tid      = v.rsp_tid;
    dc_rsp          = RSP_W'(32'hABC00) + RSP_W'(v.rsp_tid);
    #1;
    e_tag = v.e_p2v ? TAG_W'(32'h100) + TAG_W'(v.e_p2i) : '0;
    e_pma = v.e_p2v ? PMA_W'(v.e_p2i) : '0;
    e_rsp = RSP_W'(32'hABC00) + RSP_W'(v.rsp_tid);
    act_o = cl_outst;
    ok = (dc_req_valid == v.e_dv) && (cl_req_ready == v.e_rdy) && (dc_req_tag == e_tag) &&
         (dc_req_pma == e_pma) && (dc_req_abort == v.e_abort) && (act_o == v.e_outst) &&
         (idle == v.e_idle) && (cl_rsp_valid == v.e_rspv);
    if (v.e_dv) begin
      ok = ok && (dc_req_tid == v.e_tid) &&
           (dc_req == REQ_W'(32'hA0 + 32'(v.e_tid[5:4])));
    end
    for (int i = 0; i < N; i++) begin
      ok = ok && (cl_rsp[i] == e_rsp) && (cl_rsp_tid[i] == v.rsp_tid[3:0]);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got dv=%0d tid=%h rdy=%b tag=%h abort=%0d outst=%h idle=%0d rspv=%b ; want dv=%0d tid=%h rdy=%b tag=%h abort=%0d outst=%h idle=%0d rspv=%b",
               v.name, dc_req_valid, dc_req_tid, cl_req_ready, dc_req_tag, dc_req_abort,
               act_o, idle, cl_rsp_valid, v.e_dv, v.e_tid, v.e_rdy, e_tag, v.e_abort,
               v.e_outst, v.e_idle, v.e_rspv);
    end
  endtask

  initial begin
    logic [11:0] act_o;
    for (int i = 0; i < N; i++) begin
      cl_req[i]     = REQ_W'(32'hA0 + i);
      cl_req_tid[i] = TID_W'(4 + i);
      cl_req_tag[i] = TAG_W'(32'h100 + i);
      cl_req_pma[i] = PMA_W'(i);
    end
    rst = 1'b1; cl_req_valid = '0; cl_req_need_rsp = '0; cl_req_abort = '0;
    dc_req_ready = 1'b1; dc_rsp_valid = 1'b0; dc_rsp_tid = '0; dc_rsp = '0;
    repeat (2) @(negedge clk);

    // name r valid need abort rdy rv rtid | dv tid rdy p2v p2i abort outst idle rspv
    tbl.push_back(mk("reset",      0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("t1_req",     0, 4'b0010, 4'b0010, 4'b0000, 1, 0, 6'h00, 1, 6'h15, 4'b0010, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("t1_p2",      0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 1, 1, 0, oc(0,0,1,0), 0, 4'b0000));
    tbl.push_back(mk("t1_rsp",     0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 6'h15, 0, 6'h00, 4'b0000, 0, 0, 0, oc(0,0,1,0), 0, 4'b0010));
    tbl.push_back(mk("t1_idle",    0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("rr_c2",      0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h26, 4'b0100, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("rr_c3",      0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h37, 4'b1000, 1, 2, 0, oc(0,0,0,0), 0, 4'b0000));
    tbl.push_back(mk("rr_c0",      0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h04, 4'b0001, 1, 3, 0, oc(0,0,0,0), 0, 4'b0000));
    tbl.push_back(mk("rr_c1",      0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h15, 4'b0010, 1, 0, 0, oc(0,0,0,0), 0, 4'b0000));
    tbl.push_back(mk("rr_end",     0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 1, 1, 0, oc(0,0,0,0), 0, 4'b0000));
    tbl.push_back(mk("pre_lock",   0, 4'b1000, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h37, 4'b1000, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("lock_0",     0, 4'b0100, 4'b0000, 4'b0000, 0, 0, 6'h00, 1, 6'h26, 4'b0000, 1, 3, 0, oc(0,0,0,0), 0, 4'b0000));
    tbl.push_back(mk("lock_1",     0, 4'b1101, 4'b0000, 4'b0000, 0, 0, 6'h00, 1, 6'h26, 4'b0000, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("lock_2",     0, 4'b1101, 4'b0000, 4'b0000, 0, 0, 6'h00, 1, 6'h26, 4'b0000, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("lock_acc",   0, 4'b1101, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h26, 4'b0100, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("after_lock", 0, 4'b1001, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h37, 4'b1000, 1, 2, 0, oc(0,0,0,0), 0, 4'b0000));
    tbl.push_back(mk("lock_end",   0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 1, 3, 0, oc(0,0,0,0), 0, 4'b0000));
    tbl.push_back(mk("sat1",       0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 6'h00, 1, 6'h04, 4'b0001, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("sat2",       0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 6'h00, 1, 6'h04, 4'b0001, 1, 0, 0, oc(0,0,0,1), 0, 4'b0000));
    tbl.push_back(mk("sat3",       0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 6'h00, 1, 6'h04, 4'b0001, 1, 0, 0, oc(0,0,0,2), 0, 4'b0000));
    tbl.push_back(mk("sat4",       0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 6'h00, 1, 6'h04, 4'b0001, 1, 0, 0, oc(0,0,0,3), 0, 4'b0000));
    tbl.push_back(mk("sat_mask",   0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 1, 0, 0, oc(0,0,0,4), 0, 4'b0000));
    tbl.push_back(mk("sat_norsp",  0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h04, 4'b0001, 0, 0, 0, oc(0,0,0,4), 0, 4'b0000));
    tbl.push_back(mk("sat_rsp",    0, 4'b0001, 4'b0001, 4'b0000, 1, 1, 6'h04, 0, 6'h00, 4'b0000, 1, 0, 0, oc(0,0,0,4), 0, 4'b0001));
    tbl.push_back(mk("sat_reen",   0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 6'h00, 1, 6'h04, 4'b0001, 0, 0, 0, oc(0,0,0,3), 0, 4'b0000));
    tbl.push_back(mk("drain",      0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 6'h04, 0, 6'h00, 4'b0000, 1, 0, 0, oc(0,0,0,4), 0, 4'b0001));
    tbl.push_back(mk("ab_req",     0, 4'b1000, 4'b1000, 4'b0000, 1, 0, 6'h00, 1, 6'h37, 4'b1000, 0, 0, 0, oc(0,0,0,3), 0, 4'b0000));
    tbl.push_back(mk("ab_p2",      0, 4'b0000, 4'b0000, 4'b1000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 1, 3, 1, oc(1,0,0,3), 0, 4'b0000));
    tbl.push_back(mk("ab_chk",     0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 0, 0, 0, oc(0,0,0,3), 0, 4'b0000));
    tbl.push_back(mk("hold_pre",   0, 4'b1000, 4'b1000, 4'b0000, 1, 0, 6'h00, 1, 6'h37, 4'b1000, 0, 0, 0, oc(0,0,0,3), 0, 4'b0000));
    tbl.push_back(mk("hold",       0, 4'b1000, 4'b1000, 4'b0000, 1, 1, 6'h37, 1, 6'h37, 4'b1000, 1, 3, 0, oc(1,0,0,3), 0, 4'b1000));
    tbl.push_back(mk("hold_chk",   0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 1, 3, 0, oc(1,0,0,3), 0, 4'b0000));
    tbl.push_back(mk("rst_pre",    0, 4'b0100, 4'b0100, 4'b0000, 1, 0, 6'h00, 1, 6'h26, 4'b0100, 0, 0, 0, oc(1,0,0,3), 0, 4'b0000));
    tbl.push_back(mk("lock_pre",   0, 4'b0010, 4'b0000, 4'b0000, 0, 0, 6'h00, 1, 6'h15, 4'b0000, 1, 2, 0, oc(1,1,0,3), 0, 4'b0000));
    tbl.push_back(mk("rst_asrt",   1, 4'b1011, 4'b0000, 4'b0000, 0, 0, 6'h00, 1, 6'h15, 4'b0000, 0, 0, 0, oc(1,1,0,3), 0, 4'b0000));
    tbl.push_back(mk("rst_chk",    0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("rst_rr",     0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 6'h00, 1, 6'h04, 4'b0001, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));
    tbl.push_back(mk("rst_p2",     1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 1, 0, 1, oc(0,0,0,0), 0, 4'b0000));
    tbl.push_back(mk("rst_p2_chk", 0, 4'b0000, 4'b0000, 4'b0001, 1, 0, 6'h00, 0, 6'h00, 4'b0000, 0, 0, 0, oc(0,0,0,0), 1, 4'b0000));

    foreach (tbl[k]) apply(tbl[k]);

    // All clients streaming with need_rsp: one grant per cycle in order 0..3, phase 2
    // trailing by one cycle, and two outstanding responses per client at the end.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst = 1'b0; cl_req_valid = 4'b1111; cl_req_need_rsp = 4'b1111; cl_req_abort = '0;
      dc_req_ready = 1'b1; dc_rsp_valid = 1'b0;
      #1;
      n_vec++;
      if (!dc_req_valid || dc_req_tid[5:4] != 2'(k % 4) ||
          (k > 0 && dc_req_tag != TAG_W'(32'h100 + (k - 1) % 4))) begin
        n_err++;
        $display("FAIL stream_%0d: got dv=%0d idx=%0d tag=%h ; want dv=1 idx=%0d", k,
                 dc_req_valid, dc_req_tid[5:4], dc_req_tag, k % 4);
      end
    end
    @(negedge clk);
    cl_req_valid = '0;
    #1;
    act_o = cl_outst;
    n_vec++;
    if (act_o != oc(2,2,2,2) || idle || dc_req_tag != TAG_W'(32'h103)) begin
      n_err++;
      $display("FAIL stream_cnt: got outst=%h idle=%0d tag=%h ; want outst=%h idle=0 tag=103",
               act_o, idle, dc_req_tag, oc(2,2,2,2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hpdcache_core_req_arb.md
# hpdcache_core_req_arb

Round-robin arbiter that shares one HPDcache core requester port among `N_CLIENTS` upstream clients. It sequences the cache's two-phase request protocol: the request is issued in cycle 0, and tag, PMA and abort follow in cycle 1 from the same client. Responses are routed back by a client index embedded in the transaction ID. It sits between the core-side load/store/prefetch units and one `core_req_*` port of `hpdcache`, and it tracks outstanding responses per client so that a client can be drained or throttled.

## Interface
Parameters:
- `N_CLIENTS`, 4: number of upstream clients (≥2); `IDX_W = $clog2(N_CLIENTS)`.
- `REQ_W`, 128: width of the opaque request payload (offset/data/be/op/size/sid/need_rsp packed by the client).
- `TID_W`, 4: client transaction ID width; downstream TID width is `TID_W+IDX_W`.
- `TAG_W`, 44: phase-2 tag width.
- `PMA_W`, 2: phase-2 PMA width.
- `RSP_W`, 72: opaque response payload width.
- `MAX_OUTST`, 4: maximum outstanding responses per client; `CNT_W = $clog2(MAX_OUTST+1)`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `cl_req_valid_i` in N: client request valid.
- `cl_req_ready_o` out N: client request accepted.
- `cl_req_i` in N×REQ_W: request payload.
- `cl_req_tid_i` in N×TID_W: client TID.
- `cl_req_need_rsp_i` in N: request expects a response.
- `cl_req_tag_i` in N×TAG_W: phase-2 tag.
- `cl_req_pma_i` in N×PMA_W: phase-2 PMA.
- `cl_req_abort_i` in N: phase-2 abort.
- `cl_rsp_valid_o` out N: response valid to the client.
- `cl_rsp_o` out N×RSP_W: response payload, broadcast to all clients.
- `cl_rsp_tid_o` out N×TID_W: response TID, broadcast to all clients.
- `cl_outst_o` out N×CNT_W: per-client outstanding count.
- `idle_o` out 1: all counters zero and no phase 2 pending.
- `dc_req_valid_o` out 1: downstream request valid.
- `dc_req_ready_i` in 1: downstream request ready.
- `dc_req_o` out REQ_W: downstream request payload.
- `dc_req_tid_o` out TID_W+IDX_W: downstream TID, `{idx, client_tid}`.
- `dc_req_tag_o` out TAG_W: downstream phase-2 tag.
- `dc_req_pma_o` out PMA_W: downstream phase-2 PMA.
- `dc_req_abort_o` out 1: downstream phase-2 abort.
- `dc_rsp_valid_i` in 1: downstream response valid.
- `dc_rsp_i` in RSP_W: downstream response payload.
- `dc_rsp_tid_i` in TID_W+IDX_W: downstream response TID.

## Operation
- Eligibility: client i is eligible iff `cl_req_valid_i[i]`, and either `cnt[i] < MAX_OUTST` or `need_rsp[i]=0`.
- Arbitration: the grant goes to the first eligible client scanning upward from `rr_ptr`, wrapping modulo N. `dc_req_valid_o` = any grant. Payload and TID are muxed from the granted client.
- Lock: if `dc_req_valid_o & ~dc_req_ready_i`, register `lock=1` and `lock_idx=grant`.
  - While locked, the grant is forced to `lock_idx` regardless of other clients or the pointer.
  - The client must hold valid and payload stable while locked.
  - The lock clears on acceptance.
- Acceptance: acceptance is `dc_req_valid_o & dc_req_ready_i`. `cl_req_ready_o[i] = grant[i] & dc_req_ready_i`. On acceptance, `rr_ptr <= (grant+1) mod N`, `p2_valid<=1`, `p2_idx<=grant`, `p2_need<=need_rsp`.
- Phase 2 (cycle after acceptance): `dc_req_tag_o`, `dc_req_pma_o` and `dc_req_abort_o` are muxed from client `p2_idx`. When `p2_valid=0`, they are driven to 0.
- Counters, evaluated per client each cycle:
  - inc = acceptance from i with need_rsp.
  - dec = `dc_rsp_valid_i` with `dc_rsp_tid_i[TID_W+:IDX_W]==i`, or phase 2 of i with `p2_need & abort` (an aborted request yields no response).
  - Outcome: inc without dec gives +1; dec without inc gives −1; both together hold the count.
  - Counters never exceed `MAX_OUTST` and never go below 0. A dec at 0 is ignored (assertion in simulation).
- Response routing: `cl_rsp_valid_o[i] = dc_rsp_valid_i & (idx==i)`. `cl_rsp_o` and `cl_rsp_tid_o` are broadcast to all clients; `cl_rsp_tid_o` carries the low TID_W bits of `dc_rsp_tid_i`. An index ≥N drops the response.
- A new request may be accepted in the same cycle as the phase 2 of the previous one (back-to-back).

## Timing
- Request path: combinational, zero cycles from client valid to `dc_req_valid_o`. No bubble between consecutive grants.
- Phase 2: exactly one cycle after acceptance.
- Response path: combinational, zero cycles.
- Reset (`rst_i` high at a clock edge): `rr_ptr=0`, `lock=0`, `p2_valid=0`, all `cnt=0`.
  - Outputs after reset: `dc_req_valid_o=0` with no client valid; `cl_req_ready_o=0`; tag/pma/abort=0; `cl_rsp_valid_o=0`; `cl_outst_o=0`; `idle_o=1`.
- Reset asserted mid-transaction discards the lock, the phase-2 state and the counters. Upstream and downstream are reset together.
- `idle_o` is registered-state-only: `~p2_valid & (all cnt==0)`.

## Test plan
- Single client 1, TID 5, need_rsp, ready=1 → `dc_req_tid_o={1,5}`. Next cycle, tag/pma from client 1 with abort=0. `cl_outst_o[1]=1`. A response with tid `{1,5}` → `cl_rsp_valid_o[1]=1`, `cnt[1]=0`, `idle_o=1`.
- All 4 clients valid continuously, ready=1 → grants 0,1,2,3,0,… one per cycle. Each phase 2 is aligned to the previous grant.
- Client 2 granted with ready=0 for 3 cycles while clients 0 and 3 raise valid → grant stays 2. Accepted in cycle 4. Next grant is 3.
- Client 0 issues 4 need_rsp requests with no responses (MAX_OUTST=4) → client 0 is masked and client 1 is served. A response to client 0 re-enables it the next cycle.
- Abort in phase 2 for client 3, need_rsp → `cnt[3]` returns to 0 one cycle after acceptance. In the same cycle as an acceptance for client 3 and a response to client 3, the count holds.
- Reset asserted with lock=1, p2_valid=1 and cnt=3 → next cycle all state is zero, `idle_o=1` and tag/abort=0.
